// File: rtl/mux_bin_tree_pipe_pkg.sv
// Shared elaboration helpers for the pipelined binary-select mux tree.
// Covers the power-of checks, tree depth and per-level fan-out width.
package mux_pkg;

  function automatic bit is_pow(input int unsigned n, input int unsigned base);
    int unsigned v;
    if (base < 2 || n == 0) return 1'b0;
    v = n;
    while (v > 1) begin
      if (v % base != 0) return 1'b0;
      v = v / base;
    end
    return 1'b1;
  endfunction

  function automatic int unsigned levels(input int unsigned n, input int unsigned base);
    int unsigned v;
    int unsigned l;
    v = n;
    l = 0;
    while (v > 1 && base > 1) begin
      v = v / base;
      l++;
    end
    return l;
  endfunction

  // Number of values leaving level k (level 0 is the leaf level).
  function automatic int unsigned width_at(input int unsigned width, input int unsigned split,
                                           input int unsigned k);
    int unsigned v;
    v = width;
    for (int unsigned i = 0; i <= k; i++) v = v / split;
    return v;
  endfunction

endpackage

// File: rtl/mux_bin_tree_pipe_if.sv
// Select/array request stream in, selected element stream out.
interface mux_bin_tree_pipe_if #(
  parameter type DAT_T = logic [8-1:0],
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

  logic                 s_vld;
  logic                 s_rdy;
  logic [WIDTH_LOG-1:0] s_bin;
  DAT_T                 s_ary [WIDTH];
  logic                 m_vld;
  logic                 m_rdy;
  DAT_T                 m_dat;

  modport slave (input s_vld, s_bin, s_ary, m_rdy, output s_rdy, m_vld, m_dat);
  modport master (output s_vld, s_bin, s_ary, m_rdy, input s_rdy, m_vld, m_dat);
endinterface

// File: rtl/mux_bin_base.sv
// SPLIT-way binary-select mux; IMPLEMENTATION picks indexed or AND-OR form.
module mux_bin_base #(
  parameter type DAT_T = logic [8-1:0],
  parameter int unsigned WIDTH = 2,
  parameter int IMPLEMENTATION = 0
)(
  input  logic [$clog2(WIDTH)-1:0] bin,
  input  DAT_T                     ary [WIDTH],
  output DAT_T                     dat
);
  localparam int unsigned BIN_W = $clog2(WIDTH);

  if (IMPLEMENTATION == 0) begin : g_idx
    assign dat = ary[bin];
  end else begin : g_andor
    logic [$bits(DAT_T)-1:0] acc;
    always_comb begin
      acc = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (bin == BIN_W'(i)) acc = acc | $bits(DAT_T)'(ary[i]);
      end
    end
    assign dat = DAT_T'(acc);
  end
endmodule

// File: rtl/mux_bin_tree_pipe_stage.sv
// One tree level: WIDTH_IN/SPLIT muxes plus an optional valid/ready register.
module mux_bin_tree_pipe_stage #(
  parameter type DAT_T = logic [8-1:0],
  parameter int unsigned WIDTH_IN = 2,
  parameter int unsigned SPLIT = 2,
  parameter int unsigned BIN_W = 1,
  parameter bit REG = 1'b1,
  parameter int IMPLEMENTATION = 0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [BIN_W-1:0] in_bin,
  input  DAT_T             in_ary [WIDTH_IN],
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [BIN_W-1:0] out_bin,
  output DAT_T             out_ary [WIDTH_IN/SPLIT]
);
  localparam int unsigned SPLIT_LOG = $clog2(SPLIT);
  localparam int unsigned WIDTH_OUT = WIDTH_IN / SPLIT;

  DAT_T             mux_ary [WIDTH_OUT];
  logic [BIN_W-1:0] nxt_bin;

  for (genvar i = 0; i < WIDTH_OUT; i++) begin : g_mux
    DAT_T grp [SPLIT];
    for (genvar j = 0; j < SPLIT; j++) begin : g_grp
      assign grp[j] = in_ary[i*SPLIT + j];
    end
    mux_bin_base #(
      .DAT_T(DAT_T),
      .WIDTH(SPLIT),
      .IMPLEMENTATION(IMPLEMENTATION)
    ) u_mux (
      .bin(in_bin[SPLIT_LOG-1:0]),
      .ary(grp),
      .dat(mux_ary[i])
    );
  end

  // Consumed select bits are shifted out so the next level always reads the LSBs.
  assign nxt_bin = in_bin >> SPLIT_LOG;

  if (REG) begin : g_reg
    logic             vld_q;
    logic [BIN_W-1:0] bin_q;
    DAT_T             ary_q [WIDTH_OUT];

    assign in_rdy = !vld_q || out_rdy;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        bin_q <= '0;
        for (int unsigned i = 0; i < WIDTH_OUT; i++) ary_q[i] <= '0;
      end else begin
        if (in_rdy) vld_q <= in_vld;
        if (in_vld && in_rdy) begin
          bin_q <= nxt_bin;
          ary_q <= mux_ary;
        end
      end
    end

    assign out_vld = vld_q;
    assign out_bin = bin_q;
    assign out_ary = ary_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign in_rdy  = out_rdy;
    assign out_vld = in_vld;
    assign out_bin = nxt_bin;
    assign out_ary = mux_ary;
  end
endmodule

// File: rtl/mux_bin_tree_pipe.sv
// Pipelined SPLIT-way binary-select mux tree; PIPE[k] registers level k.
module mux_bin_tree_pipe
  import mux_pkg::*;
#(
  parameter type DAT_T = logic [8-1:0],
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPLIT = 2,
  localparam int unsigned LEVELS = levels(WIDTH, SPLIT),
  parameter logic [LEVELS-1:0] PIPE = '1,
  parameter int IMPLEMENTATION = 0
)(
  input logic               clk,
  input logic               rst,
  mux_bin_tree_pipe_if.slave bus
);
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

  if (!is_pow(WIDTH, SPLIT)) begin : g_err_width
    $error("mux_bin_tree_pipe: WIDTH must be a power of SPLIT");
  end
  if (!is_pow(SPLIT, 2)) begin : g_err_split
    $error("mux_bin_tree_pipe: SPLIT must be a power of 2, at least 2");
  end
  if ($bits(PIPE) != LEVELS) begin : g_err_pipe
    $error("mux_bin_tree_pipe: PIPE must be LEVELS bits wide");
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned W_OUT = width_at(WIDTH, SPLIT, k);
    localparam int unsigned W_IN  = W_OUT * SPLIT;

    logic                 in_vld, in_rdy, out_vld, out_rdy;
    logic [WIDTH_LOG-1:0] in_bin, out_bin;
    DAT_T                 in_ary  [W_IN];
    DAT_T                 out_ary [W_OUT];

    if (k == 0) begin : g_head
      assign in_vld    = bus.s_vld;
      assign in_bin    = bus.s_bin;
      assign in_ary    = bus.s_ary;
      assign bus.s_rdy = in_rdy;
    end else begin : g_link
      assign in_vld = g_lvl[k-1].out_vld;
      assign in_bin = g_lvl[k-1].out_bin;
      assign in_ary = g_lvl[k-1].out_ary;
    end

    if (k == LEVELS - 1) begin : g_tail
      assign out_rdy = bus.m_rdy;
    end else begin : g_fwd
      assign out_rdy = g_lvl[k+1].in_rdy;
    end

    mux_bin_tree_pipe_stage #(
      .DAT_T(DAT_T),
      .WIDTH_IN(W_IN),
      .SPLIT(SPLIT),
      .BIN_W(WIDTH_LOG),
      .REG(PIPE[k]),
      .IMPLEMENTATION(IMPLEMENTATION)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .in_vld(in_vld),
      .in_rdy(in_rdy),
      .in_bin(in_bin),
      .in_ary(in_ary),
      .out_vld(out_vld),
      .out_rdy(out_rdy),
      .out_bin(out_bin),
      .out_ary(out_ary)
    );
  end

  assign bus.m_vld = g_lvl[LEVELS-1].out_vld;
  assign bus.m_dat = g_lvl[LEVELS-1].out_ary[0];

  // After the last level every select bit has been consumed.
  logic unused_bin;
  assign unused_bin = ^g_lvl[LEVELS-1].out_bin;
endmodule

// File: tb/tb_mux_bin_tree_pipe.sv
// Self-checking bench: three configurations against cycle-level and ordering models.
module tb_mux_bin_tree_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  mux_bin_tree_pipe_if #(.WIDTH(16)) ia ();
  mux_bin_tree_pipe_if #(.WIDTH(16)) ib ();
  mux_bin_tree_pipe_if #(.WIDTH(64)) ic ();

  mux_bin_tree_pipe #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(2), .PIPE(4'b1111),
                      .IMPLEMENTATION(0))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mux_bin_tree_pipe #(.DAT_T(logic [7:0]), .WIDTH(16), .SPLIT(2), .PIPE(4'b0000),
                      .IMPLEMENTATION(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  mux_bin_tree_pipe #(.DAT_T(logic [7:0]), .WIDTH(64), .SPLIT(4), .PIPE(3'b010),
                      .IMPLEMENTATION(0))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model A: four slots, each either empty or holding one selected value.
  logic       a_sv [4];
  logic [7:0] a_sd [4];
  logic [7:0] a_q [$];
  logic [7:0] a_ary [16];

  task automatic cycle_a(input logic v, input logic [3:0] bin, input logic mrdy, input logic r);
    logic rdy [5];
    logic [7:0] front;
    @(negedge clk);
    rst = r;
    ia.s_vld = v; ia.s_bin = bin; ia.m_rdy = mrdy; ia.s_ary = a_ary;
    #1;
    rdy[4] = mrdy;
    for (int k = 3; k >= 0; k--) rdy[k] = !a_sv[k] || rdy[k+1];
    check("a_s_rdy", 32'(ia.s_rdy), 32'(rdy[0]));
    check("a_m_vld", 32'(ia.m_vld), 32'(a_sv[3]));
    check("a_m_dat", 32'(ia.m_dat), 32'(a_sd[3]));
    if (a_sv[3] && mrdy) begin
      check("a_result_expected", 32'(a_q.size() != 0), 32'd1);
      if (a_q.size() != 0) begin
        front = a_q.pop_front();
        check("a_order", 32'(ia.m_dat), 32'(front));
      end
    end
    if (r) begin
      for (int k = 0; k < 4; k++) begin a_sv[k] = 1'b0; a_sd[k] = '0; end
      a_q.delete();
    end else begin
      if (v && rdy[0]) a_q.push_back(a_ary[bin]);
      for (int k = 3; k >= 0; k--) begin
        if (rdy[k]) begin
          if (k == 0) begin
            if (v) a_sd[0] = a_ary[bin];
            a_sv[0] = v;
          end else begin
            if (a_sv[k-1]) a_sd[k] = a_sd[k-1];
            a_sv[k] = a_sv[k-1];
          end
        end
      end
    end
  endtask

  // Model C: single slot of latency.
  logic       c_sv;
  logic [7:0] c_sd;
  logic [7:0] c_ary [64];

  task automatic cycle_c(input logic v, input logic [5:0] bin, input logic mrdy);
    logic rdy;
    @(negedge clk);
    rst = 1'b0;
    ic.s_vld = v; ic.s_bin = bin; ic.m_rdy = mrdy; ic.s_ary = c_ary;
    #1;
    rdy = !c_sv || mrdy;
    check("c_s_rdy", 32'(ic.s_rdy), 32'(rdy));
    check("c_m_vld", 32'(ic.m_vld), 32'(c_sv));
    check("c_m_dat", 32'(ic.m_dat), 32'(c_sd));
    if (rdy) begin
      if (v) c_sd = c_ary[bin];
      c_sv = v;
    end
  endtask

  task automatic step_b(input logic v, input logic [3:0] bin, input logic mrdy);
    @(negedge clk);
    ib.s_vld = v; ib.s_bin = bin; ib.m_rdy = mrdy;
    #1;
    check("b_m_vld", 32'(ib.m_vld), 32'(v));
    check("b_s_rdy", 32'(ib.s_rdy), 32'(mrdy));
    check("b_m_dat", 32'(ib.m_dat), 32'(ib.s_ary[bin]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ia.s_vld = 0; ia.s_bin = '0; ia.m_rdy = 0;
    ib.s_vld = 0; ib.s_bin = '0; ib.m_rdy = 0;
    ic.s_vld = 0; ic.s_bin = '0; ic.m_rdy = 0;
    for (int i = 0; i < 16; i++) begin a_ary[i] = 8'h10 + 8'(i); ib.s_ary[i] = 8'h10 + 8'(i); end
    for (int i = 0; i < 64; i++) c_ary[i] = 8'(i);
    ia.s_ary = a_ary; ic.s_ary = c_ary;
    for (int k = 0; k < 4; k++) begin a_sv[k] = 1'b0; a_sd[k] = '0; end
    c_sv = 1'b0; c_sd = '0;
    repeat (3) @(posedge clk);

    // Reset state, then 0..15 back to back: results 8'h10..8'h1F at latency 4.
    cycle_a(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cycle_a(1, 4'(i), 1, 0);
    repeat (5) cycle_a(0, 0, 1, 0);

    // Backpressure: four held, s_rdy falls, then drain in order.
    for (int i = 0; i < 4; i++) cycle_a(1, 4'(i * 3), 0, 0);
    repeat (3) cycle_a(1, 4'd5, 0, 0);
    repeat (6) cycle_a(0, 0, 1, 0);

    // Bubble collapse under a stalled output.
    cycle_a(1, 4'd2, 0, 0);
    repeat (2) cycle_a(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle_a(1, 4'(7 + i), 0, 0);
    repeat (6) cycle_a(0, 0, 1, 0);

    // Reset with three in flight: nothing of them may surface.
    for (int i = 0; i < 3; i++) cycle_a(1, 4'(12 + i), 0, 0);
    cycle_a(0, 0, 0, 1);
    repeat (6) cycle_a(0, 0, 1, 0);

    // Random traffic with random data, stalls and occasional reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 16; i++) a_ary[i] = 8'($urandom);
      cycle_a($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 60) == 0);
    end
    repeat (6) cycle_a(0, 0, 1, 0);
    check("a_drain_empty", 32'(a_q.size()), 32'd0);

    // Fully combinational configuration.
    step_b(1, 4'd9, 1);
    check("b_bin9", 32'(ib.m_dat), 32'h19);
    step_b(0, 4'd3, 0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) ib.s_ary[i] = 8'($urandom);
      step_b(1'($urandom), 4'($urandom), 1'($urandom));
    end

    // WIDTH=64, SPLIT=4, register after level 1 only.
    cycle_c(1, 6'd63, 1);
    cycle_c(1, 6'd0, 1);
    check("c_first", 32'(ic.m_dat), 32'd63);
    cycle_c(0, 6'd0, 1);
    check("c_second", 32'(ic.m_dat), 32'd0);
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 64; i++) c_ary[i] = 8'($urandom);
      cycle_c($urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
